// File: rtl/dup_stream_finder.sv
// Streaming duplicate detector: compares each accepted word against a ring-buffer history
// of unique words and registers a (dup, slot) result one cycle later, plus saturating stats.
module dup_stream_finder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_dup,
  output logic [$clog2(DEPTH)-1:0]   out_idx,
  output logic                       hist_full,
  output logic [CNT_W-1:0]           dup_count,
  output logic [CNT_W-1:0]           uniq_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] hist_data_q [DEPTH];
  logic [WIDTH-1:0] hist_data_d [DEPTH];
  logic [DEPTH-1:0] hist_vld_q, hist_vld_d;
  logic [IDX_W-1:0] wptr_q, wptr_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_dup_q, out_dup_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;

  logic [CNT_W-1:0] dup_cnt_q, dup_cnt_d;
  logic [CNT_W-1:0] uniq_cnt_q, uniq_cnt_d;

  logic             acc;
  logic             match;
  logic [IDX_W-1:0] midx;

  assign in_ready = (!out_valid_q || out_ready) && !clear;
  assign acc      = in_valid && in_ready;

  // Lowest-index hit wins.
  always_comb begin
    match = 1'b0;
    midx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!match && hist_vld_q[i] && (hist_data_q[i] == in_data)) begin
        match = 1'b1;
        midx  = IDX_W'(i);
      end
    end
  end

  always_comb begin
    hist_data_d = hist_data_q;
    hist_vld_d  = hist_vld_q;
    wptr_d      = wptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_dup_d   = out_dup_q;
    out_idx_d   = out_idx_q;
    dup_cnt_d   = dup_cnt_q;
    uniq_cnt_d  = uniq_cnt_q;

    if (clear) begin
      hist_vld_d  = '0;
      wptr_d      = '0;
      out_valid_d = 1'b0;
      dup_cnt_d   = '0;
      uniq_cnt_d  = '0;
    end else if (acc) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      if (match) begin
        out_dup_d = 1'b1;
        out_idx_d = midx;
        if (dup_cnt_q != {CNT_W{1'b1}}) dup_cnt_d = dup_cnt_q + CNT_W'(1);
      end else begin
        out_dup_d           = 1'b0;
        out_idx_d           = wptr_q;
        hist_data_d[wptr_q] = in_data;
        hist_vld_d[wptr_q]  = 1'b1;
        // DEPTH is a power of two, so the natural wrap gives FIFO replacement.
        wptr_d              = wptr_q + IDX_W'(1);
        if (uniq_cnt_q != {CNT_W{1'b1}}) uniq_cnt_d = uniq_cnt_q + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_vld_q  <= '0;
      wptr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dup_q   <= 1'b0;
      out_idx_q   <= '0;
      dup_cnt_q   <= '0;
      uniq_cnt_q  <= '0;
    end else begin
      hist_vld_q  <= hist_vld_d;
      wptr_q      <= wptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_dup_q   <= out_dup_d;
      out_idx_q   <= out_idx_d;
      dup_cnt_q   <= dup_cnt_d;
      uniq_cnt_q  <= uniq_cnt_d;
    end
  end

  // Payload is qualified by hist_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    hist_data_q <= hist_data_d;
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_dup    = out_dup_q;
  assign out_idx    = out_idx_q;
  assign hist_full  = &hist_vld_q;
  assign dup_count  = dup_cnt_q;
  assign uniq_count = uniq_cnt_q;

endmodule

// File: tb/tb_dup_stream_finder.sv
// Scoreboard bench for dup_stream_finder: the driver queues expected results on acceptance,
// a negedge monitor pops and compares each result as it is handed downstream.
module tb_dup_stream_finder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned IDX_W = 2;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_dup;
  logic [IDX_W-1:0] out_idx;
  logic             hist_full;
  logic [CNT_W-1:0] dup_count;
  logic [CNT_W-1:0] uniq_count;

  int n_vec  = 0;
  int n_fail = 0;
  logic [WIDTH+IDX_W:0] sb [$];

  dup_stream_finder #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_dup   (out_dup),
    .out_idx   (out_idx),
    .hist_full (hist_full),
    .dup_count (dup_count),
    .uniq_count(uniq_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every result handed downstream must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("result_unexpected", {21'd0, out_data, out_dup, out_idx}, 32'hFFFF_FFFF);
      end else begin
        logic [WIDTH+IDX_W:0] e;
        e = sb.pop_front();
        chk("result", {21'd0, out_data, out_dup, out_idx}, {21'd0, e});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic dup, input logic [IDX_W-1:0] idx,
                      output int waits);
    in_valid = 1'b1;
    in_data  = d;
    waits    = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back({d, dup, idx});
        break;
      end
      waits++;
      if (waits > 20) begin
        chk("send_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
  endtask

  initial begin
    int w;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    idle(2);
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_counts", {dup_count, uniq_count}, 32'd0);
    chk("rst_hist_full", 32'(hist_full), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic dup detection
    out_ready = 1'b1;
    send(8'h11, 1'b0, 2'd0, w);
    send(8'h22, 1'b0, 2'd1, w);
    send(8'h11, 1'b1, 2'd0, w);
    chk("basic_uniq", 32'(uniq_count), 32'd2);
    chk("basic_dup", 32'(dup_count), 32'd1);
    idle(1);
    pulse_clear();
    chk("clr_counts", {dup_count, uniq_count}, 32'd0);

    // Fill and FIFO eviction
    send(8'hA0, 1'b0, 2'd0, w);
    send(8'hA1, 1'b0, 2'd1, w);
    send(8'hA2, 1'b0, 2'd2, w);
    chk("fill_not_full", 32'(hist_full), 32'd0);
    send(8'hA3, 1'b0, 2'd3, w);
    chk("fill_full", 32'(hist_full), 32'd1);
    chk("uniq_sat", 32'(uniq_count), 32'd3);
    send(8'hA4, 1'b0, 2'd0, w);
    send(8'hA0, 1'b0, 2'd1, w);
    send(8'hA2, 1'b1, 2'd2, w);
    chk("evict_dup_cnt", 32'(dup_count), 32'd1);

    // Backpressure: result A2/dup/2 held, nothing accepted, stats frozen
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold", {21'd0, out_data, out_dup, out_idx}, {21'd0, 8'hA2, 1'b1, 2'd2});
      chk("bp_counts", {dup_count, uniq_count}, {28'd0, 2'd1, 2'd3});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(8'h55, 1'b0, 2'd2, w);
    chk("bp_release_same_cycle", 32'(w), 32'd0);

    // Clear with a pending result; input during clear is ignored
    out_ready = 1'b0;
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    idle(1);
    clear    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_counts2", {dup_count, uniq_count}, 32'd0);
    chk("clr_hist_full", 32'(hist_full), 32'd0);
    out_ready = 1'b1;
    clear     = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_no_accept", 32'(out_valid), 32'd0);
    send(8'h11, 1'b0, 2'd0, w);

    // Counter saturation with CNT_W=2
    idle(1);
    pulse_clear();
    send(8'h33, 1'b0, 2'd0, w);
    send(8'h33, 1'b1, 2'd0, w);
    send(8'h33, 1'b1, 2'd0, w);
    chk("dup_cnt_2", 32'(dup_count), 32'd2);
    send(8'h33, 1'b1, 2'd0, w);
    send(8'h33, 1'b1, 2'd0, w);
    chk("dup_cnt_sat", 32'(dup_count), 32'd3);
    chk("uniq_cnt_1", 32'(uniq_count), 32'd1);

    // Asynchronous reset between edges while a result is pending
    out_ready = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_outputs", {21'd0, out_data, out_dup, out_idx}, 32'd0);
    chk("arst_counts", {dup_count, uniq_count}, 32'd0);
    chk("arst_hist_full", 32'(hist_full), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(8'h33, 1'b0, 2'd0, w);
    idle(2);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
